min_ratio_channel_select: RTL and testbench

- Producer side of the transmission-estimation channel selection. Generates the 2-bit channel select that the Fc and Inv_Ac multiplexers consume.
- For each filtered pixel it computes F_c * Inv_A_c for c in {R,G,B}. It returns the index of the smallest product, together with the pixel and inverse-A values that go with it.
- Sits between the guided/min filter output and the transmission-estimation muxes.
- Pipelined with valid/ready flow control. Holds the atmospheric-light inverses in internal registers.

---
 rtl/min_ratio_channel_select.sv | 173 +++++++++++++++++
 tb/tb_min_ratio_channel_select.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/min_ratio_channel_select.sv
// rtl/min_ratio_channel_select.sv - picks the channel with the smallest F_c * Inv_A_c product
module min_ratio_channel_select #(
    parameter int PIX_W  = 8,
    parameter int INV_W  = 10,
    parameter int PROD_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inva_load,
    input  logic [INV_W-1:0]  Inv_AR_in,
    input  logic [INV_W-1:0]  Inv_AG_in,
    input  logic [INV_W-1:0]  Inv_AB_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  F_R,
    input  logic [PIX_W-1:0]  F_G,
    input  logic [PIX_W-1:0]  F_B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        sel,
    output logic [PROD_W-1:0] min_prod,
    output logic [PIX_W-1:0]  F_R_o,
    output logic [PIX_W-1:0]  F_G_o,
    output logic [PIX_W-1:0]  F_B_o,
    output logic [INV_W-1:0]  Inv_AR_o,
    output logic [INV_W-1:0]  Inv_AG_o,
    output logic [INV_W-1:0]  Inv_AB_o
);

    typedef enum logic [1:0] {WAIT_A, RUN, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [2:0][INV_W-1:0]    inva_q, inva_d, pend_q, pend_d;
    logic [2:0][INV_W-1:0]    inv_in;
    logic [2:0][PIX_W-1:0]    f_in;

    logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [2:0][PROD_W-1:0]   p1_q, p1_d;
    logic [2:0][PIX_W-1:0]    f1_q, f1_d, f2_q, f2_d, f3_q, f3_d;
    logic [2:0][INV_W-1:0]    i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [1:0]               rg_sel_q, rg_sel_d, sel_q, sel_d;
    logic [PROD_W-1:0]        rg_min_q, rg_min_d, pb_q, pb_d, min_q, min_d;
    logic                     en;

    // Element 0 is R, 1 is G, 2 is B so the index matches the sel encoding.
    assign f_in   = {F_B, F_G, F_R};
    assign inv_in = {Inv_AB_in, Inv_AG_in, Inv_AR_in};

    assign en       = !v3_q || out_ready;
    assign in_ready = (state_q == RUN) && en && !inva_load;

    always_comb begin
        state_d  = state_q;
        inva_d   = inva_q;
        pend_d   = pend_q;
        v1_d     = v1_q;
        p1_d     = p1_q;
        f1_d     = f1_q;
        i1_d     = i1_q;
        v2_d     = v2_q;
        rg_sel_d = rg_sel_q;
        rg_min_d = rg_min_q;
        pb_d     = pb_q;
        f2_d     = f2_q;
        i2_d     = i2_q;
        v3_d     = v3_q;
        sel_d    = sel_q;
        min_d    = min_q;
        f3_d     = f3_q;
        i3_d     = i3_q;

        case (state_q)
            WAIT_A: begin
                if (inva_load) begin
                    inva_d  = inv_in;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (inva_load) begin
                    pend_d  = inv_in;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inva_load) begin
                    pend_d = inv_in;
                end
                // A load arriving on the commit cycle is the newest value, so it wins.
                if (!v1_q && !v2_q && !v3_q) begin
                    inva_d  = inva_load ? inv_in : pend_q;
                    state_d = RUN;
                end
            end
            default: state_d = WAIT_A;
        endcase

        if (en) begin
            v1_d = in_valid && in_ready;
            f1_d = f_in;
            i1_d = inva_q;
            for (int c = 0; c < 3; c++) begin
                p1_d[c] = PROD_W'(f_in[c]) * PROD_W'(inva_q[c]);
            end

            v2_d     = v1_q;
            rg_sel_d = (p1_q[1] < p1_q[0]) ? 2'b01 : 2'b00;
            rg_min_d = (p1_q[1] < p1_q[0]) ? p1_q[1] : p1_q[0];
            pb_d     = p1_q[2];
            f2_d     = f1_q;
            i2_d     = i1_q;

            v3_d  = v2_q;
            sel_d = (pb_q < rg_min_q) ? 2'b10 : rg_sel_q;
            min_d = (pb_q < rg_min_q) ? pb_q : rg_min_q;
            f3_d  = f2_q;
            i3_d  = i2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_A;
            inva_q   <= '0;
            pend_q   <= '0;
            v1_q     <= 1'b0;
            p1_q     <= '0;
            f1_q     <= '0;
            i1_q     <= '0;
            v2_q     <= 1'b0;
            rg_sel_q <= 2'b00;
            rg_min_q <= '0;
            pb_q     <= '0;
            f2_q     <= '0;
            i2_q     <= '0;
            v3_q     <= 1'b0;
            sel_q    <= 2'b00;
            min_q    <= '0;
            f3_q     <= '0;
            i3_q     <= '0;
        end else begin
            state_q  <= state_d;
            inva_q   <= inva_d;
            pend_q   <= pend_d;
            v1_q     <= v1_d;
            p1_q     <= p1_d;
            f1_q     <= f1_d;
            i1_q     <= i1_d;
            v2_q     <= v2_d;
            rg_sel_q <= rg_sel_d;
            rg_min_q <= rg_min_d;
            pb_q     <= pb_d;
            f2_q     <= f2_d;
            i2_q     <= i2_d;
            v3_q     <= v3_d;
            sel_q    <= sel_d;
            min_q    <= min_d;
            f3_q     <= f3_d;
            i3_q     <= i3_d;
        end
    end

    assign out_valid = v3_q;
    assign sel       = sel_q;
    assign min_prod  = min_q;
    assign F_R_o     = f3_q[0];
    assign F_G_o     = f3_q[1];
    assign F_B_o     = f3_q[2];
    assign Inv_AR_o  = i3_q[0];
    assign Inv_AG_o  = i3_q[1];
    assign Inv_AB_o  = i3_q[2];

endmodule

// File: tb/tb_min_ratio_channel_select.sv
// tb/tb_min_ratio_channel_select.sv - scoreboard bench for min_ratio_channel_select
module tb_min_ratio_channel_select;

    logic        clk = 1'b0;
    logic        rst;
    logic        inva_load;
    logic [9:0]  Inv_AR_in, Inv_AG_in, Inv_AB_in;
    logic        in_valid, in_ready;
    logic [7:0]  F_R, F_G, F_B;
    logic        out_valid, out_ready;
    logic [1:0]  sel;
    logic [17:0] min_prod;
    logic [7:0]  F_R_o, F_G_o, F_B_o;
    logic [9:0]  Inv_AR_o, Inv_AG_o, Inv_AB_o;

    min_ratio_channel_select dut (
        .clk(clk), .rst(rst), .inva_load(inva_load),
        .Inv_AR_in(Inv_AR_in), .Inv_AG_in(Inv_AG_in), .Inv_AB_in(Inv_AB_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .F_R(F_R), .F_G(F_G), .F_B(F_B),
        .out_valid(out_valid), .out_ready(out_ready),
        .sel(sel), .min_prod(min_prod),
        .F_R_o(F_R_o), .F_G_o(F_G_o), .F_B_o(F_B_o),
        .Inv_AR_o(Inv_AR_o), .Inv_AG_o(Inv_AG_o), .Inv_AB_o(Inv_AB_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [17:0] mp;
        logic [23:0] pix;
        logic [29:0] inv;
        int          t;
    } exp_t;

    exp_t        sb[$];
    logic [9:0]  mi [3];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          chk_lat = 1'b1;
    bit          held = 1'b0;
    logic [63:0] snap;
    bit          acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] out_word();
        return {5'd0, out_valid, sel, min_prod, F_R_o, F_G_o, F_B_o};
    endfunction

    task automatic push_expected();
        exp_t e;
        int   p [3];
        int   s;
        p[0] = int'(F_R) * int'(mi[0]);
        p[1] = int'(F_G) * int'(mi[1]);
        p[2] = int'(F_B) * int'(mi[2]);
        s = 0;
        for (int c = 1; c < 3; c++) if (p[c] < p[s]) s = c;
        e.sel = 2'(s);
        e.mp  = 18'(p[s]);
        e.pix = {F_R, F_G, F_B};
        e.inv = {mi[0], mi[1], mi[2]};
        e.t   = cyc;
        sb.push_back(e);
    endtask

    // One clock: observe handshakes at the negedge, then return 1 after the posedge.
    task automatic step(output bit accepted);
        exp_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (held && !rst) chk("hold_stable", out_word(), snap);
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sel", 64'(sel), 64'(e.sel));
                chk("min_prod", 64'(min_prod), 64'(e.mp));
                chk("pix_out", 64'({F_R_o, F_G_o, F_B_o}), 64'(e.pix));
                chk("inv_out", 64'({Inv_AR_o, Inv_AG_o, Inv_AB_o}), 64'(e.inv));
                if (chk_lat) chk("latency", 64'(cyc - e.t), 64'd3);
            end
        end
        held = out_valid && !out_ready;
        snap = out_word();
        if (in_valid && in_ready) begin
            push_expected();
            accepted = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input bit toggle);
        int n = 0;
        bit a = 1'b0;
        F_R = r; F_G = g; F_B = b;
        in_valid = 1'b1;
        while (!a && n < 20) begin
            if (toggle) out_ready = !out_ready;
            step(a);
            n++;
        end
        in_valid = 1'b0;
        chk("accept_timeout", 64'(a), 64'd1);
    endtask

    task automatic load(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        bit a;
        Inv_AR_in = r; Inv_AG_in = g; Inv_AB_in = b;
        inva_load = 1'b1;
        mi[0] = r; mi[1] = g; mi[2] = b;
        step(a);
        inva_load = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        bit a;
        out_ready = 1'b1;
        while (sb.size() > 0 && n < 40) begin
            step(a);
            n++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; inva_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Inv_AR_in = '0; Inv_AG_in = '0; Inv_AB_in = '0;
        F_R = '0; F_G = '0; F_B = '0;
        mi[0] = '0; mi[1] = '0; mi[2] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_min_prod", 64'(min_prod), 64'd0);
        chk("rst_data", 64'({F_R_o, F_G_o, F_B_o, Inv_AR_o, Inv_AG_o, Inv_AB_o}), 64'd0);
        rst = 1'b0;

        // No inverse loaded yet: pixels must be refused.
        F_R = 8'd3; F_G = 8'd4; F_B = 8'd5; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("wait_a_in_ready", 64'(in_ready), 64'd0);
            step(acc);
        end
        chk("wait_a_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;

        load(10'd100, 10'd200, 10'd300);
        send(8'd10, 8'd4, 8'd5, 1'b0);
        wait_empty();

        load(10'd256, 10'd256, 10'd256);
        send(8'd7, 8'd7, 8'd7, 1'b0);
        send(8'd9, 8'd7, 8'd7, 1'b0);
        send(8'd255, 8'd255, 8'd254, 1'b0);
        wait_empty();

        load(10'd0, 10'd0, 10'd0);
        send(8'd3, 8'd2, 8'd1, 1'b0);
        wait_empty();

        // Back-to-back stream with out_ready toggling every cycle.
        load(10'd100, 10'd200, 10'd300);
        chk_lat = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(8'(i * 37 + 5), 8'(255 - i * 29), 8'(i * 13 + 90), 1'b1);
        end
        wait_empty();
        chk_lat = 1'b1;

        // Reload with three results in flight; the pixel offered alongside is refused.
        send(8'd10, 8'd4, 8'd5, 1'b0);
        send(8'd20, 8'd1, 8'd9, 1'b0);
        send(8'd1, 8'd2, 8'd3, 1'b0);
        F_R = 8'd1; F_G = 8'd255; F_B = 8'd200; in_valid = 1'b1;
        Inv_AR_in = 10'd1023; Inv_AG_in = 10'd1; Inv_AB_in = 10'd1; inva_load = 1'b1;
        #1;
        chk("load_blocks_in", 64'(in_ready), 64'd0);
        load(10'd1023, 10'd1, 10'd1);
        chk("drain_in_ready", 64'(in_ready), 64'd0);
        chk("drain_sb_depth", 64'(sb.size() > 0), 64'd1);
        send(8'd1, 8'd255, 8'd200, 1'b0);
        wait_empty();

        // Reset while a result is held at the output.
        out_ready = 1'b0;
        chk_lat = 1'b0;
        send(8'd5, 8'd6, 8'd7, 1'b0);
        for (int i = 0; i < 3; i++) step(acc);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        held = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        F_R = 8'd1; F_G = 8'd1; F_B = 8'd1; in_valid = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) step(acc);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        chk("post_rst_inv_cleared", 64'({Inv_AR_o, Inv_AG_o, Inv_AB_o}), 64'd0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
